// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and load-store results in per-source FIFOs
// and broadcasts one registered result per cycle, alternating under contention.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback_flag_from_rob,

  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_jump,
  input  logic [DATA_W-1:0] alu_target,
  output logic              alu_ready,

  input  logic              ls_valid,
  input  logic [ROB_W-1:0]  ls_rob_id,
  input  logic [DATA_W-1:0] ls_result,
  output logic              ls_ready,

  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_id,
  output logic [DATA_W-1:0] cdb_result,
  output logic              cdb_jump,
  output logic [DATA_W-1:0] cdb_target,
  output logic              cdb_src
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] result;
    logic              jump;
    logic [DATA_W-1:0] target;
  } entry_t;

  // NOTE: FIFO storage carries no reset; counts and pointers alone decide which slots are live.
  entry_t            alu_mem_q [DEPTH];
  entry_t            alu_mem_d [DEPTH];
  entry_t            ls_mem_q  [DEPTH];
  entry_t            ls_mem_d  [DEPTH];
  logic [PTR_W-1:0]  alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0]  ls_wr_q, ls_wr_d, ls_rd_q, ls_rd_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, ls_cnt_q, ls_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_src_q, cdb_src_d;
  entry_t            cdb_q, cdb_d;

  logic alu_push, ls_push, grant_alu, grant_ls;

  assign alu_ready = rdy & ~rollback_flag_from_rob & (alu_cnt_q != FULL);
  assign ls_ready  = rdy & ~rollback_flag_from_rob & (ls_cnt_q != FULL);

  // Zero ROB ids are handshaken so the producer moves on, but never stored.
  assign alu_push = alu_valid & alu_ready & (alu_rob_id != '0);
  assign ls_push  = ls_valid & ls_ready & (ls_rob_id != '0);

  // last_grant = 1 means LS won last time, so ALU has priority now.
  assign grant_alu = (alu_cnt_q != '0) & ((ls_cnt_q == '0) | last_grant_q);
  assign grant_ls  = (ls_cnt_q != '0) & ~grant_alu;

  always_comb begin
    // NOTE: every *_d is defaulted to its *_q first so no path through this block infers a latch.
    alu_mem_d    = alu_mem_q;
    ls_mem_d     = ls_mem_q;
    alu_wr_d     = alu_wr_q;
    alu_rd_d     = alu_rd_q;
    ls_wr_d      = ls_wr_q;
    ls_rd_d      = ls_rd_q;
    alu_cnt_d    = alu_cnt_q;
    ls_cnt_d     = ls_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_src_d    = cdb_src_q;
    cdb_d        = cdb_q;

    if (rst) begin
      alu_wr_d     = '0;
      alu_rd_d     = '0;
      ls_wr_d      = '0;
      ls_rd_d      = '0;
      alu_cnt_d    = '0;
      ls_cnt_d     = '0;
      last_grant_d = 1'b1;
      cdb_valid_d  = 1'b0;
      cdb_src_d    = 1'b0;
      cdb_d        = '0;
    end else if (rollback_flag_from_rob) begin
      alu_wr_d     = '0;
      alu_rd_d     = '0;
      ls_wr_d      = '0;
      ls_rd_d      = '0;
      alu_cnt_d    = '0;
      ls_cnt_d     = '0;
      last_grant_d = 1'b1;
      cdb_valid_d  = 1'b0;
    end else if (rdy) begin
      if (alu_push) begin
        alu_mem_d[alu_wr_q] = '{rob_id: alu_rob_id, result: alu_result,
                                jump: alu_jump, target: alu_target};
        alu_wr_d = alu_wr_q + PTR_W'(1);
      end
      if (ls_push) begin
        ls_mem_d[ls_wr_q] = '{rob_id: ls_rob_id, result: ls_result,
                              jump: 1'b0, target: '0};
        ls_wr_d = ls_wr_q + PTR_W'(1);
      end
      if (grant_alu) begin
        cdb_d     = alu_mem_q[alu_rd_q];
        cdb_src_d = 1'b0;
        alu_rd_d  = alu_rd_q + PTR_W'(1);
      end else if (grant_ls) begin
        cdb_d     = ls_mem_q[ls_rd_q];
        cdb_src_d = 1'b1;
        ls_rd_d   = ls_rd_q + PTR_W'(1);
      end
      alu_cnt_d   = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(grant_alu);
      ls_cnt_d    = ls_cnt_q + CNT_W'(ls_push) - CNT_W'(grant_ls);
      cdb_valid_d = grant_alu | grant_ls;
      if (grant_alu | grant_ls) last_grant_d = grant_ls;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk) begin
    alu_mem_q    <= alu_mem_d;
    ls_mem_q     <= ls_mem_d;
    alu_wr_q     <= alu_wr_d;
    alu_rd_q     <= alu_rd_d;
    ls_wr_q      <= ls_wr_d;
    ls_rd_q      <= ls_rd_d;
    alu_cnt_q    <= alu_cnt_d;
    ls_cnt_q     <= ls_cnt_d;
    last_grant_q <= last_grant_d;
    cdb_valid_q  <= cdb_valid_d;
    cdb_src_q    <= cdb_src_d;
    cdb_q        <= cdb_d;
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_q.rob_id;
  assign cdb_result = cdb_q.result;
  assign cdb_jump   = cdb_q.jump;
  assign cdb_target = cdb_q.target;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, contention, backpressure,
// rollback, freeze, zero-id discard and mid-operation reset.
module tb_cdb_arbiter;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst, rdy, rollback_flag_from_rob;
  logic              alu_valid, alu_jump, alu_ready;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [DATA_W-1:0] alu_result, alu_target;
  logic              ls_valid, ls_ready;
  logic [ROB_W-1:0]  ls_rob_id;
  logic [DATA_W-1:0] ls_result;
  logic              cdb_valid, cdb_jump, cdb_src;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_result, cdb_target;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .rollback_flag_from_rob (rollback_flag_from_rob),
    .alu_valid              (alu_valid),
    .alu_rob_id             (alu_rob_id),
    .alu_result             (alu_result),
    .alu_jump               (alu_jump),
    .alu_target             (alu_target),
    .alu_ready              (alu_ready),
    .ls_valid               (ls_valid),
    .ls_rob_id              (ls_rob_id),
    .ls_result              (ls_result),
    .ls_ready               (ls_ready),
    .cdb_valid              (cdb_valid),
    .cdb_rob_id             (cdb_rob_id),
    .cdb_result             (cdb_result),
    .cdb_jump               (cdb_jump),
    .cdb_target             (cdb_target),
    .cdb_src                (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [ROB_W-1:0] id, input logic src);
    check({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      check({tag, ".rob_id"}, 64'(cdb_rob_id), 64'(id));
      check({tag, ".src"}, 64'(cdb_src), 64'(src));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 1'b0;
    alu_rob_id = '0;
    alu_result = '0;
    alu_jump   = 1'b0;
    alu_target = '0;
    ls_valid   = 1'b0;
    ls_rob_id  = '0;
    ls_result  = '0;
  endtask

  task automatic offer_alu(input logic [ROB_W-1:0] id, input logic [DATA_W-1:0] res,
                           input logic j, input logic [DATA_W-1:0] tgt);
    alu_valid  = 1'b1;
    alu_rob_id = id;
    alu_result = res;
    alu_jump   = j;
    alu_target = tgt;
  endtask

  task automatic offer_ls(input logic [ROB_W-1:0] id, input logic [DATA_W-1:0] res);
    ls_valid  = 1'b1;
    ls_rob_id = id;
    ls_result = res;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    rollback_flag_from_rob = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_v   [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_id  [10] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 0};
  int exp_src [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    int  a_id, l_id;
    logic alu_on, a_acc, l_acc;

    // Reset values
    do_reset();
    check("rst.cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst.cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    check("rst.cdb_result", 64'(cdb_result), 64'd0);
    check("rst.cdb_jump", 64'(cdb_jump), 64'd0);
    check("rst.cdb_target", 64'(cdb_target), 64'd0);
    check("rst.cdb_src", 64'(cdb_src), 64'd0);
    check("rst.alu_ready", 64'(alu_ready), 64'd1);
    check("rst.ls_ready", 64'(ls_ready), 64'd1);

    // Single ALU result: accepted at edge 1, broadcast at edge 2, idle at edge 3
    offer_alu(4'd3, 32'h2A, 1'b1, 32'h100);
    tick();
    idle();
    chk_cdb("single.e1", 1'b0, '0, 1'b0);
    tick();
    chk_cdb("single.e2", 1'b1, 4'd3, 1'b0);
    check("single.e2.result", 64'(cdb_result), 64'h2A);
    check("single.e2.jump", 64'(cdb_jump), 64'd1);
    check("single.e2.target", 64'(cdb_target), 64'h100);
    tick();
    chk_cdb("single.e3", 1'b0, '0, 1'b0);
    check("single.e3.rob_hold", 64'(cdb_rob_id), 64'd3);

    // Contention: order 1,5,2,6 with ALU first
    do_reset();
    offer_alu(4'd1, 32'h11, 1'b1, 32'h44);
    offer_ls(4'd5, 32'h55);
    #1;
    check("cont.alu_ready", 64'(alu_ready), 64'd1);
    check("cont.ls_ready", 64'(ls_ready), 64'd1);
    tick();
    chk_cdb("cont.e1", 1'b0, '0, 1'b0);
    offer_alu(4'd2, 32'h22, 1'b0, 32'h0);
    offer_ls(4'd6, 32'h66);
    tick();
    chk_cdb("cont.e2", 1'b1, 4'd1, 1'b0);
    check("cont.e2.result", 64'(cdb_result), 64'h11);
    idle();
    #1;
    check("cont.ls_full_ready", 64'(ls_ready), 64'd0);
    tick();
    chk_cdb("cont.e3", 1'b1, 4'd5, 1'b1);
    check("cont.e3.result", 64'(cdb_result), 64'h55);
    check("cont.e3.jump", 64'(cdb_jump), 64'd0);
    check("cont.e3.target", 64'(cdb_target), 64'd0);
    tick();
    chk_cdb("cont.e4", 1'b1, 4'd2, 1'b0);
    tick();
    chk_cdb("cont.e5", 1'b1, 4'd6, 1'b1);
    tick();
    chk_cdb("cont.e6", 1'b0, '0, 1'b0);

    // Backpressure: LS ids 1..4 against a busy ALU stream starting at id 8
    do_reset();
    a_id   = 8;
    l_id   = 1;
    alu_on = 1'b1;
    for (int e = 0; e < 10; e++) begin
      alu_valid  = alu_on;
      alu_rob_id = ROB_W'(a_id);
      alu_result = DATA_W'(a_id);
      ls_valid   = (l_id <= 4);
      ls_rob_id  = ROB_W'(l_id);
      ls_result  = DATA_W'(l_id);
      #1;
      a_acc = alu_valid & alu_ready;
      l_acc = ls_valid & ls_ready;
      if (e == 2 || e == 4) check($sformatf("bp.pre_e%0d.ls_ready", e + 1), 64'(ls_ready), 64'd0);
      tick();
      if (a_acc) a_id++;
      if (l_acc) l_id++;
      if (l_id > 4) alu_on = 1'b0;
      chk_cdb($sformatf("bp.e%0d", e + 1), exp_v[e] != 0, ROB_W'(exp_id[e]), exp_src[e] != 0);
    end
    idle();

    // Rollback with ALU=[2], LS=[5,6] buffered and LS holding priority
    do_reset();
    offer_alu(4'd1, 32'h1, 1'b0, 32'h0);
    offer_ls(4'd5, 32'h5);
    tick();
    offer_alu(4'd2, 32'h2, 1'b0, 32'h0);
    offer_ls(4'd6, 32'h6);
    tick();
    chk_cdb("rb.pre", 1'b1, 4'd1, 1'b0);
    rollback_flag_from_rob = 1'b1;
    offer_alu(4'd3, 32'h3, 1'b0, 32'h0);
    offer_ls(4'd7, 32'h7);
    #1;
    check("rb.alu_ready", 64'(alu_ready), 64'd0);
    check("rb.ls_ready", 64'(ls_ready), 64'd0);
    tick();
    rollback_flag_from_rob = 1'b0;
    idle();
    chk_cdb("rb.e1", 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb($sformatf("rb.quiet%0d", i), 1'b0, '0, 1'b0);
    end
    offer_alu(4'd9, 32'h9, 1'b0, 32'h0);
    offer_ls(4'd10, 32'hA);
    tick();
    idle();
    tick();
    chk_cdb("rb.after1", 1'b1, 4'd9, 1'b0);
    tick();
    chk_cdb("rb.after2", 1'b1, 4'd10, 1'b1);
    tick();
    chk_cdb("rb.after3", 1'b0, '0, 1'b0);

    // Freeze: rdy low for 3 cycles holds cdb and FIFO contents
    do_reset();
    offer_alu(4'd7, 32'h77, 1'b0, 32'h0);
    tick();
    offer_alu(4'd8, 32'h88, 1'b0, 32'h0);
    offer_ls(4'd3, 32'h33);
    tick();
    chk_cdb("frz.pre", 1'b1, 4'd7, 1'b0);
    rdy = 1'b0;
    offer_alu(4'd9, 32'h99, 1'b0, 32'h0);
    idle();
    offer_alu(4'd9, 32'h99, 1'b0, 32'h0);
    #1;
    check("frz.alu_ready", 64'(alu_ready), 64'd0);
    check("frz.ls_ready", 64'(ls_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb($sformatf("frz.hold%0d", i), 1'b1, 4'd7, 1'b0);
      check($sformatf("frz.hold%0d.result", i), 64'(cdb_result), 64'h77);
    end
    rdy = 1'b1;
    idle();
    tick();
    chk_cdb("frz.resume1", 1'b1, 4'd3, 1'b1);
    tick();
    chk_cdb("frz.resume2", 1'b1, 4'd8, 1'b0);
    tick();
    chk_cdb("frz.resume3", 1'b0, '0, 1'b0);

    // Zero ROB id: acknowledged, never broadcast
    offer_alu(4'd0, 32'hDEAD, 1'b1, 32'h4);
    offer_ls(4'd0, 32'hBEEF);
    #1;
    check("zero.alu_ready", 64'(alu_ready), 64'd1);
    check("zero.ls_ready", 64'(ls_ready), 64'd1);
    tick();
    idle();
    tick();
    chk_cdb("zero.e2", 1'b0, '0, 1'b0);
    tick();
    chk_cdb("zero.e3", 1'b0, '0, 1'b0);

    // Mid-operation reset discards buffered entries
    offer_alu(4'd5, 32'h5, 1'b0, 32'h0);
    offer_ls(4'd6, 32'h6);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.cdb_valid", 64'(cdb_valid), 64'd0);
    check("mrst.cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    tick();
    chk_cdb("mrst.e1", 1'b0, '0, 1'b0);
    tick();
    chk_cdb("mrst.e2", 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
